hex_scan_display: RTL and testbench

- Downstream display stage for the hex calculator: latches the 32-bit calculation result on a one-cycle update strobe.
- Time-multiplexes the 8 hex nibbles onto the 8-digit common-anode seven-segment array, one digit at a time.
- Sits between the calculator core (result + button strobe) and the board LED pins, in the divided clock domain.

---
 rtl/hex_scan_display.sv | 146 ++++++++++++++
 tb/tb_hex_scan_display.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/hex_scan_display.sv
`default_nettype none
// ============================================================================
// Module      : hex_scan_display
// Description : Display stage for the hex calculator. Latches a 32-bit
//               result on a one-cycle update strobe and time-multiplexes its
//               8 hex nibbles onto an 8-digit common-anode seven-segment
//               array. One digit is enabled at a time for SCAN_DIV cycles.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   SCAN_DIV  clock cycles each digit stays enabled (>= 2)
// Ports:
//   clk       in   1   divided system clock
//   rst       in   1   asynchronous reset, active-low
//   update    in   1   one-cycle strobe: latch value
//   value     in  32   result; nibble i -> digit i, digit 0 = rightmost
//   led_en    out  8   digit enables, active-low (one-hot-low while scanning)
//   led_ca..  out  1   segments a..g, active-low
//   led_cg
//   led_dp    out  1   decimal point, active-low, held off (1)
// Optional build macro:
//   LEADING_ZERO_BLANK_EN  blank digits above the highest nonzero nibble
//                          (digit 0 is never blanked)
// ============================================================================
module hex_scan_display #(
  parameter int SCAN_DIV = 20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        update,
  input  logic [31:0] value,
  output logic [7:0]  led_en,
  output logic        led_ca,
  output logic        led_cb,
  output logic        led_cc,
  output logic        led_cd,
  output logic        led_ce,
  output logic        led_cf,
  output logic        led_cg,
  output logic        led_dp
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(SCAN_DIV - 1);
  localparam logic [6:0]       c_seg_off = 7'b1111111;

  logic [31:0]      r_shown;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic [7:0]       r_led_en;
  logic [6:0]       r_seg;      // {a,b,c,d,e,f,g}, active-low

  logic [3:0]       w_nib;
  logic [6:0]       w_seg;
  logic [7:0]       w_en;
  logic             w_blank;

  // Nibble currently being scanned; {idx,2'b00} keeps the bit offset 5 bits wide.
  always_comb begin
    w_nib = r_shown[{r_idx, 2'b00} +: 4];
  end

  always_comb begin
    w_seg = c_seg_off;
    case (w_nib)
      4'h0: w_seg = 7'b0000001;
      4'h1: w_seg = 7'b1001111;
      4'h2: w_seg = 7'b0010010;
      4'h3: w_seg = 7'b0000110;
      4'h4: w_seg = 7'b1001100;
      4'h5: w_seg = 7'b0100100;
      4'h6: w_seg = 7'b0100000;
      4'h7: w_seg = 7'b0001111;
      4'h8: w_seg = 7'b0000000;
      4'h9: w_seg = 7'b0000100;
      4'hA: w_seg = 7'b0001000;
      4'hB: w_seg = 7'b1100000;
      4'hC: w_seg = 7'b0110001;
      4'hD: w_seg = 7'b1000010;
      4'hE: w_seg = 7'b0110000;
      4'hF: w_seg = 7'b0111000;
      default: w_seg = c_seg_off;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Index of the highest nonzero nibble; stays 0 for an all-zero value so
  // digit 0 is always shown.
  logic [2:0] w_top;
  always_comb begin
    w_top = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (r_shown[4*i +: 4] != 4'd0) w_top = 3'(i);
    end
    w_blank = (r_idx > w_top);
  end
`else
  always_comb begin
    w_blank = 1'b0;
  end
`endif

  always_comb begin
    w_en = ~(8'b0000_0001 << r_idx);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shown  <= 32'd0;
      r_cnt    <= '0;
      r_idx    <= 3'd0;
      r_led_en <= 8'hFF;
      r_seg    <= c_seg_off;
    end else begin
      if (update) r_shown <= value;

      if (r_cnt == c_cnt_max) begin
        r_cnt <= '0;
        r_idx <= r_idx + 3'd1;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      // Pins follow idx/shown one cycle later.
      if (w_blank) begin
        r_led_en <= 8'hFF;
        r_seg    <= c_seg_off;
      end else begin
        r_led_en <= w_en;
        r_seg    <= w_seg;
      end
    end
  end

  assign led_en = r_led_en;
  assign led_ca = r_seg[6];
  assign led_cb = r_seg[5];
  assign led_cc = r_seg[4];
  assign led_cd = r_seg[3];
  assign led_ce = r_seg[2];
  assign led_cf = r_seg[1];
  assign led_cg = r_seg[0];
  assign led_dp = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_hex_scan_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_hex_scan_display
// Description : Scoreboard bench for hex_scan_display with SCAN_DIV = 4.
//               A reference model of shown/cnt/idx pushes the expected pin
//               word for the next edge; each edge pops and compares it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hex_scan_display;

  localparam int SCAN_DIV = 4;

  logic        clk;
  logic        rst;
  logic        update;
  logic [31:0] value;
  logic [7:0]  led_en;
  logic        led_ca, led_cb, led_cc, led_cd, led_ce, led_cf, led_cg, led_dp;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] q_exp[$];

  // Reference model state
  logic [31:0] m_shown;
  int          m_cnt;
  int          m_idx;

  hex_scan_display #(.SCAN_DIV(SCAN_DIV)) u_dut (
    .clk    (clk),
    .rst    (rst),
    .update (update),
    .value  (value),
    .led_en (led_en),
    .led_ca (led_ca),
    .led_cb (led_cb),
    .led_cc (led_cc),
    .led_cd (led_cd),
    .led_ce (led_ce),
    .led_cf (led_cf),
    .led_cg (led_cg),
    .led_dp (led_dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] seg_code(input logic [3:0] n);
    logic [6:0] tbl [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                             7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                             7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                             7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    return tbl[n];
  endfunction

  // Expected {led_en, a..g, dp} for a given digit index and latched value.
  function automatic logic [15:0] exp_word(input int idx, input logic [31:0] sh);
    logic [7:0] en;
    logic [3:0] nib;
    int         top;
    en  = 8'hFF;
    en[idx] = 1'b0;
    nib = sh[idx*4 +: 4];
    top = 0;
    for (int i = 0; i < 8; i++) if (sh[i*4 +: 4] != 4'd0) top = i;
`ifdef LEADING_ZERO_BLANK_EN
    if (idx > top) return {8'hFF, 7'h7F, 1'b1};
`endif
    return {en, seg_code(nib), 1'b1};
  endfunction

  function automatic logic [15:0] pins();
    return {led_en, led_ca, led_cb, led_cc, led_cd, led_ce, led_cf, led_cg, led_dp};
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_shown = 32'd0;
    m_cnt   = 0;
    m_idx   = 0;
    q_exp.delete();
    q_exp.push_back(exp_word(0, 32'd0));
  endtask

  // One clock: drive inputs, compare the pins produced by this edge, then
  // advance the model and queue the expectation for the following edge.
  task automatic cycle(input logic upd, input logic [31:0] val, input string tag);
    update = upd;
    value  = val;
    @(posedge clk);
    #1;
    if (q_exp.size() == 0) check({tag, "_noexp"}, 16'h0000, 16'hFFFF);
    else                   check(tag, pins(), q_exp.pop_front());
    if (upd) m_shown = val;
    if (m_cnt == SCAN_DIV - 1) begin
      m_cnt = 0;
      m_idx = (m_idx + 1) % 8;
    end else begin
      m_cnt++;
    end
    q_exp.push_back(exp_word(m_idx, m_shown));
  endtask

  task automatic wait_phase(input int idx, input int cnt, input string tag);
    int n;
    n = 0;
    while (!(m_idx == idx && m_cnt == cnt) && n < 64) begin
      cycle(1'b0, 32'd0, tag);
      n++;
    end
    if (n >= 64) check({tag, "_timeout"}, 16'h0000, 16'hFFFF);
  endtask

  initial begin
    rst    = 1'b1;
    update = 1'b0;
    value  = 32'd0;
    #3 rst = 1'b0;
    #1 check("rst_state", pins(), {8'hFF, 7'h7F, 1'b1});
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    model_reset();

    // First edge after release shows digit 0 of zero
    cycle(1'b0, 32'd0, "first");
    check("first_pins", pins(), exp_word(0, 32'd0));

    // Full walk over all digits
    cycle(1'b1, 32'h89ABCDEF, "walk_upd");
    for (int i = 0; i < 40; i++) cycle(1'b0, 32'd0, "walk");

    // Update while idx=0 mid-dwell
    wait_phase(0, 0, "pre_u1");
    cycle(1'b1, 32'h00000001, "u1");
    cycle(1'b0, 32'd0, "u1_next");
    check("u1_seg", pins(), {8'hFE, 7'b1001111, 1'b1});

    // Update coinciding with the dwell wrap
    wait_phase(0, SCAN_DIV - 1, "pre_wrap");
    cycle(1'b1, 32'h12345678, "wrap_upd");
    cycle(1'b0, 32'd0, "wrap_next");
    check("wrap_pins", pins(), {8'hFD, 7'b0001111, 1'b1});

    // Update held high with a changing value
    for (int i = 0; i < 20; i++) cycle(1'b1, $urandom, "held");
    cycle(1'b0, 32'd0, "held_end");

    // Leading-zero candidates
    cycle(1'b1, 32'h000000A5, "a5_upd");
    for (int i = 0; i < 34; i++) cycle(1'b0, 32'd0, "a5");
    cycle(1'b1, 32'h00000000, "z_upd");
    for (int i = 0; i < 34; i++) cycle(1'b0, 32'd0, "zero");

    // Reset mid-scan, then a full dwell from idx 0
    cycle(1'b1, 32'hFEDCBA98, "pre_rst");
    cycle(1'b0, 32'd0, "pre_rst2");
    rst = 1'b0;
    #1 check("rst_mid", pins(), {8'hFF, 7'h7F, 1'b1});
    #1 rst = 1'b1;
    model_reset();
    for (int i = 0; i < 12; i++) cycle(1'b0, 32'd0, "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
